// File: rtl/instr_wb_master.sv
// Single-beat Wishbone pipelined master driven by instrumentation request pulses.
// One transaction at a time; completes on ack or aborts after a configurable timeout.
module instr_wb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    output logic        wb_cyc_o,
    input  logic        wb_stall_i,
    input  logic        req_i,
    input  logic [31:0] req_adr_i,
    input  logic [31:0] req_dat_i,
    input  logic        req_we_i,
    input  logic [3:0]  req_sel_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        timeout_o
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_REQUEST  = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK = 2'd2;

    // Counter holds (cycles of cyc_o high - 1), so expiry is at TIMEOUT_CYCLES-1.
    localparam logic [15:0] TO_LAST =
        16'((TIMEOUT_CYCLES == 0) ? 0 : (TIMEOUT_CYCLES - 1));
    localparam logic TO_EN = (TIMEOUT_CYCLES != 0);

    logic [1:0]  state;
    logic [15:0] to_cnt;
    logic        to_hit;
    logic        ack_ok;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign to_hit = TO_EN && (to_cnt >= TO_LAST);
    // An ack is only accepted once the request has left the stalled address phase.
    assign ack_ok = wb_ack_i && !(state == ST_REQUEST && wb_stall_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            to_cnt    <= 16'd0;
            wb_adr_o  <= 32'd0;
            wb_dat_o  <= 32'd0;
            wb_we_o   <= 1'b0;
            wb_sel_o  <= 4'd0;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            rdata_o   <= 32'd0;
            timeout_o <= 1'b0;
        end else begin
            done_o    <= 1'b0;
            timeout_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_i) begin
                        wb_adr_o <= req_adr_i;
                        wb_dat_o <= req_dat_i;
                        wb_we_o  <= req_we_i;
                        wb_sel_o <= req_sel_i;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        busy_o   <= 1'b1;
                        to_cnt   <= 16'd0;
                        state    <= ST_REQUEST;
                    end
                end
                ST_REQUEST, ST_WAIT_ACK: begin
                    if (ack_ok) begin
                        if (!wb_we_o) rdata_o <= wb_dat_i;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        busy_o   <= 1'b0;
                        done_o   <= 1'b1;
                        state    <= ST_IDLE;
                    end else if (to_hit) begin
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        busy_o    <= 1'b0;
                        timeout_o <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        to_cnt <= sat_inc(to_cnt);
                        if (state == ST_REQUEST && !wb_stall_i) begin
                            wb_stb_o <= 1'b0;
                            state    <= ST_WAIT_ACK;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_wb_master.sv
// Directed bench for instr_wb_master with a transaction-level reference model
// compared every cycle, plus literal expectations at key cycles.
module tb_instr_wb_master;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i, req_adr_i, req_dat_i, rdata_o;
    logic        wb_we_o, wb_stb_o, wb_ack_i, wb_cyc_o, wb_stall_i;
    logic [3:0]  wb_sel_o, req_sel_i;
    logic        req_i, req_we_i, busy_o, done_o, timeout_o;

    int checks = 0;
    int failures = 0;
    int n_done = 0;
    int n_to = 0;

    instr_wb_master #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
        .wb_ack_i(wb_ack_i), .wb_cyc_o(wb_cyc_o), .wb_stall_i(wb_stall_i),
        .req_i(req_i), .req_adr_i(req_adr_i), .req_dat_i(req_dat_i),
        .req_we_i(req_we_i), .req_sel_i(req_sel_i),
        .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction tracked by age in cycles.
    logic        m_ok = 1'b0;
    logic        m_active, m_stb, m_we, m_done, m_to;
    logic [31:0] m_adr, m_dat, m_rdata;
    logic [3:0]  m_sel;
    int          m_age;
    logic        m_ack_ok;

    always @(posedge clk) begin
        m_ok = 1'b1;
        if (rst_i) begin
            m_active = 0; m_stb = 0; m_we = 0; m_done = 0; m_to = 0;
            m_adr = 0; m_dat = 0; m_rdata = 0; m_sel = 0; m_age = 0;
        end else begin
            m_done = 0;
            m_to = 0;
            if (!m_active) begin
                if (req_i) begin
                    m_active = 1; m_stb = 1; m_age = 0;
                    m_adr = req_adr_i; m_dat = req_dat_i;
                    m_we = req_we_i; m_sel = req_sel_i;
                end
            end else begin
                m_age++;
                m_ack_ok = wb_ack_i && !(m_stb && wb_stall_i);
                if (m_ack_ok) begin
                    if (!m_we) m_rdata = wb_dat_i;
                    m_active = 0; m_stb = 0; m_done = 1;
                end else if (T > 0 && m_age >= T) begin
                    m_active = 0; m_stb = 0; m_to = 1;
                end else if (m_stb && !wb_stall_i) begin
                    m_stb = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("cyc", {31'd0, wb_cyc_o}, {31'd0, m_active});
            chk("stb", {31'd0, wb_stb_o}, {31'd0, m_stb});
            chk("busy", {31'd0, busy_o}, {31'd0, m_active});
            chk("done", {31'd0, done_o}, {31'd0, m_done});
            chk("timeout", {31'd0, timeout_o}, {31'd0, m_to});
            chk("adr", wb_adr_o, m_adr);
            chk("wdat", wb_dat_o, m_dat);
            chk("we", {31'd0, wb_we_o}, {31'd0, m_we});
            chk("sel", {28'd0, wb_sel_o}, {28'd0, m_sel});
            chk("rdata", rdata_o, m_rdata);
            if (done_o) n_done++;
            if (timeout_o) n_to++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] adr, input logic [31:0] dat, input logic we);
        req_i = 1; req_adr_i = adr; req_dat_i = dat; req_we_i = we; req_sel_i = 4'hF;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst_i = 1; req_i = 0; req_adr_i = 0; req_dat_i = 0; req_we_i = 0; req_sel_i = 0;
        wb_dat_i = 0; wb_ack_i = 0; wb_stall_i = 0;
        tick();
        issue(32'h0000_0AAA, 32'h0, 1'b0);   // dropped: arrives during reset
        tick();
        chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("rst_adr", wb_adr_o, 32'd0);
        rst_i = 0; req_i = 0;
        tick();
        chk("req_in_rst_dropped", {31'd0, busy_o}, 32'd0);

        // Read, no stall
        issue(32'h100, 32'h0, 1'b0);
        tick();
        chk("rd_c1_stb", {31'd0, wb_stb_o}, 32'd1);
        req_i = 0;
        tick();
        chk("rd_c2_stb", {31'd0, wb_stb_o}, 32'd0);
        wb_ack_i = 1; wb_dat_i = 32'hDEADBEEF;
        tick();
        chk("rd_c3_done", {31'd0, done_o}, 32'd1);
        chk("rd_c3_rdata", rdata_o, 32'hDEADBEEF);
        chk("rd_c3_cyc", {31'd0, wb_cyc_o}, 32'd0);
        wb_ack_i = 0;
        tick();

        // Write with 3 stall cycles; ack under stall is ignored
        issue(32'h4, 32'h12345678, 1'b1);
        wb_stall_i = 1;
        tick();
        req_i = 0;
        tick();
        wb_ack_i = 1; wb_dat_i = 32'h0BAD0BAD;
        tick();
        wb_ack_i = 0;
        chk("wr_c3_busy", {31'd0, busy_o}, 32'd1);
        tick();
        chk("wr_c4_stb", {31'd0, wb_stb_o}, 32'd1);
        chk("wr_c4_dat", wb_dat_o, 32'h12345678);
        wb_stall_i = 0;
        tick();
        chk("wr_c5_stb", {31'd0, wb_stb_o}, 32'd0);
        wb_ack_i = 1; wb_dat_i = 32'hCAFEF00D;
        tick();
        chk("wr_done", {31'd0, done_o}, 32'd1);
        chk("wr_rdata_kept", rdata_o, 32'hDEADBEEF);
        wb_ack_i = 0;
        tick();

        // Timeout: no ack for 8 cycles of cyc_o
        d0 = n_done;
        issue(32'h200, 32'h0, 1'b0);
        tick();
        req_i = 0;
        for (int i = 0; i < T; i++) tick();
        chk("to_pulse", {31'd0, timeout_o}, 32'd1);
        chk("to_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("to_no_done", n_done, d0);
        issue(32'h300, 32'h0, 1'b0);
        tick();
        chk("after_to_busy", {31'd0, busy_o}, 32'd1);
        req_i = 0;
        tick();
        wb_ack_i = 1; wb_dat_i = 32'h11111111;
        tick();
        wb_ack_i = 0;
        chk("after_to_rdata", rdata_o, 32'h11111111);
        tick();

        // Ack on the expiry cycle wins over timeout
        issue(32'h400, 32'h0, 1'b0);
        tick();
        req_i = 0;
        for (int i = 0; i < T - 1; i++) tick();
        wb_ack_i = 1; wb_dat_i = 32'h22222222;
        tick();
        wb_ack_i = 0;
        chk("prio_done", {31'd0, done_o}, 32'd1);
        chk("prio_no_to", {31'd0, timeout_o}, 32'd0);
        tick();

        // Back-to-back with req_i held high while busy
        d0 = n_done;
        issue(32'h500, 32'h0, 1'b0);
        tick();
        req_adr_i = 32'h999;
        tick();
        wb_ack_i = 1; wb_dat_i = 32'h33333333;
        tick();
        wb_ack_i = 0;
        req_adr_i = 32'h600;
        chk("b2b_done1", {31'd0, done_o}, 32'd1);
        tick();
        chk("b2b_adr2", wb_adr_o, 32'h600);
        tick();
        req_i = 0;
        wb_ack_i = 1; wb_dat_i = 32'h44444444;
        tick();
        wb_ack_i = 0;
        tick(); tick();
        chk("b2b_count", n_done - d0, 32'd2);
        chk("b2b_rdata", rdata_o, 32'h44444444);

        // Reset during WAIT_ACK, then late ack
        d0 = n_done;
        issue(32'h700, 32'h55, 1'b1);
        tick();
        req_i = 0;
        tick();
        rst_i = 1;
        tick();
        rst_i = 0;
        chk("rst_mid_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("rst_mid_rdata", rdata_o, 32'd0);
        chk("rst_mid_sel", {28'd0, wb_sel_o}, 32'd0);
        wb_ack_i = 1; wb_dat_i = 32'h66666666;
        tick();
        wb_ack_i = 0;
        tick();
        chk("rst_no_done", n_done, d0);
        chk("to_total", n_to, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
